instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising-edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: in_valid  in  1  request valid; in_ready  out  1  request accepted when both high.
REQ-004 SHALL have ports: imm_src  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U-LUI, 101 U-AUIPC, 110/111 illegal.
REQ-005 SHALL have ports: opcode  in  7; rd, rs1, rs2  in  5 each; funct3  in  3; imm  in  32  sign-extended immediate value.
REQ-006 SHALL have ports: out_valid  out  1; out_ready  in  1; instr  out  32  encoded word; err  out  1; err_code  out  2.
REQ-007 SHALL have ports: cnt_ok  out  16  good words emitted; cnt_err  out  16  error words emitted.

Function
REQ-008 SHALL be the inverse of the immediate extender: for err=0, extending instr with the same imm_src SHALL return imm exactly.
REQ-009 SHALL be a 2-stage pipeline: S1 registers request and computes error; S2 registers assembled word; latency 2 cycles from accept to out_valid with no stall.
REQ-010 SHALL advance each stage when it is empty or the next stage empties/moves in the same cycle; in_ready = !S1.valid or S1 advancing.
REQ-011 SHALL hold instr/err/err_code stable while out_valid=1 and out_ready=0; no request lost, duplicated or reordered; full throughput of 1 word/cycle.
REQ-012 SHALL error-check, precedence high to low: illegal imm_src -> 11; B/J with imm[0]=1 -> 10; range violation -> 01; else 00.
REQ-013 SHALL range-check: I/S imm[31:11] all equal; B imm[31:12] all equal; J imm[31:20] all equal; U imm[11:0]=0.
REQ-014 SHALL assemble I: imm[11:0],rs1,funct3,rd,opcode; S: imm[11:5],rs2,rs1,funct3,imm[4:0],opcode.
REQ-015 SHALL assemble B: imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode; J: imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode; U: imm[31:12],rd,opcode.
REQ-016 SHALL output instr=32'h00000013 (NOP) with err=1 whenever err_code!=00; err = |err_code.
REQ-017 SHALL increment cnt_ok or cnt_err by 1 on each output handshake (out_valid && out_ready), saturating at 16'hFFFF.
REQ-018 SHALL drive instr/err_code to 0 when out_valid=0.

Reset
REQ-019 SHALL, on rst low, immediately clear both stage valids, cnt_ok, cnt_err, instr, err, err_code; in_ready=1 and out_valid=0 during reset.
REQ-020 SHALL discard in-flight words on reset mid-operation; first accept after rst rises produces output 2 cycles later.

Structure
REQ-021 SHALL take imm_src encodings, error codes and the NOP constant from a shared core package also used by the extender.
REQ-022 SHALL contain one combinational sub-module imm_pack (format + fields -> 32-bit word) instantiated in S2; all state in instr_encoder.

Verification
REQ-023 SHALL check I: imm_src=000, imm=FFFFFFFF, rs1=1, rd=5, funct3=0, opcode=13h -> instr FFF08293h, err_code 00, 2 cycles later.
REQ-024 SHALL check B: imm_src=010, imm=8, rs1=1, rs2=2, funct3=0, opcode=63h -> 00208463h; imm=5 -> err_code 10, instr 00000013h, cnt_err=1.
REQ-025 SHALL check U/range: imm_src=100, imm=12345000h, rd=10, opcode=37h -> 12345537h; imm_src=000, imm=00000800h -> err_code 01; imm_src=111 -> 11.
REQ-026 SHALL check backpressure: out_ready=0 for 4 cycles while 3 requests offered -> in_ready falls after 2 accepts, all 3 emitted in order once out_ready=1, none lost.
REQ-027 SHALL check reset mid-stream: assert rst with both stages full -> out_valid=0, counters 0 immediately; random round-trip through extender for 10k legal requests -> imm matches.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared core definitions for the immediate extender/encoder pair:
// immediate format encodings, error codes, the NOP word and the error check.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    IMM_I       = 3'b000,
    IMM_S       = 3'b001,
    IMM_B       = 3'b010,
    IMM_J       = 3'b011,
    IMM_U_LUI   = 3'b100,
    IMM_U_AUIPC = 3'b101,
    IMM_RSVD6   = 3'b110,
    IMM_RSVD7   = 3'b111
  } imm_src_e;

  localparam logic [1:0]  ERR_NONE    = 2'b00;
  localparam logic [1:0]  ERR_RANGE   = 2'b01;
  localparam logic [1:0]  ERR_ALIGN   = 2'b10;
  localparam logic [1:0]  ERR_ILLEGAL = 2'b11;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef struct packed {
    imm_src_e    src;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
  } enc_req_t;

  // Highest-priority error wins: illegal format, then misalignment, then range.
  function automatic logic [1:0] check_err(input imm_src_e src, input logic [31:0] imm);
    logic       range_ok;
    logic [1:0] code;
    case (src)
      IMM_I, IMM_S:           range_ok = (&imm[31:11]) | ~(|imm[31:11]);
      IMM_B:                  range_ok = (&imm[31:12]) | ~(|imm[31:12]);
      IMM_J:                  range_ok = (&imm[31:20]) | ~(|imm[31:20]);
      IMM_U_LUI, IMM_U_AUIPC: range_ok = (imm[11:0] == 12'h000);
      default:                range_ok = 1'b1;
    endcase
    if ((src == IMM_RSVD6) || (src == IMM_RSVD7)) begin
      code = ERR_ILLEGAL;
    end else if (((src == IMM_B) || (src == IMM_J)) && imm[0]) begin
      code = ERR_ALIGN;
    end else if (!range_ok) begin
      code = ERR_RANGE;
    end else begin
      code = ERR_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bus of the instruction encoder; master drives requests
// and consumes encoded words, slave is the encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_src;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] cnt_ok;
  logic [15:0] cnt_err;

  modport master (
    output in_valid, imm_src, opcode, rd, rs1, rs2, funct3, imm, out_ready,
    input  in_ready, out_valid, instr, err, err_code, cnt_ok, cnt_err
  );

  modport slave (
    input  in_valid, imm_src, opcode, rd, rs1, rs2, funct3, imm, out_ready,
    output in_ready, out_valid, instr, err, err_code, cnt_ok, cnt_err
  );
endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Combinational field packer: scatters immediate bits and register fields
// into the 32-bit instruction word for the selected format.
module imm_pack
  import instr_encoder_pkg::*;
(
  input  imm_src_e    src,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  output logic [31:0] word
);

  // Format-dependent bit placement; reserved formats yield zero.
  always_comb begin
    word = 32'h0000_0000;
    case (src)
      IMM_I:                  word = {imm[11:0], rs1, funct3, rd, opcode};
      IMM_S:                  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      IMM_B:                  word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      IMM_J:                  word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      IMM_U_LUI, IMM_U_AUIPC: word = {imm[31:12], rd, opcode};
      default:                word = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage instruction encoder: S1 captures the request and its error code,
// S2 holds the packed word (or NOP on error) until the consumer takes it.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus
);

  logic        s1_valid_r;
  enc_req_t    s1_req_r;
  logic [1:0]  s1_err_r;
  logic        s2_valid_r;
  logic [31:0] s2_instr_r;
  logic [1:0]  s2_err_r;
  logic [15:0] cnt_ok_r;
  logic [15:0] cnt_err_r;

  logic        s2_adv_s;
  logic        in_ready_s;
  logic        accept_s;
  logic        fire_s;
  enc_req_t    req_s;
  logic [31:0] packed_s;
  logic [31:0] s2_instr_s;

  assign s2_adv_s   = !s2_valid_r || bus.out_ready;
  assign in_ready_s = !s1_valid_r || s2_adv_s;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign fire_s     = s2_valid_r && bus.out_ready;

  // Gather the incoming request into one record.
  always_comb begin
    req_s        = '0;
    req_s.src    = imm_src_e'(bus.imm_src);
    req_s.imm    = bus.imm;
    req_s.opcode = bus.opcode;
    req_s.rd     = bus.rd;
    req_s.rs1    = bus.rs1;
    req_s.rs2    = bus.rs2;
    req_s.funct3 = bus.funct3;
  end

  // Stage 1: request register and its error classification.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_r <= 1'b0;
      s1_req_r   <= '0;
      s1_err_r   <= ERR_NONE;
    end else if (in_ready_s) begin
      s1_valid_r <= bus.in_valid;
      if (accept_s) begin
        s1_req_r <= req_s;
        s1_err_r <= check_err(req_s.src, req_s.imm);
      end
    end
  end

  imm_pack u_imm_pack (
    .src    (s1_req_r.src),
    .imm    (s1_req_r.imm),
    .opcode (s1_req_r.opcode),
    .rd     (s1_req_r.rd),
    .rs1    (s1_req_r.rs1),
    .rs2    (s1_req_r.rs2),
    .funct3 (s1_req_r.funct3),
    .word   (packed_s)
  );

  // Any error replaces the word with a NOP; an empty slot reads as zero.
  always_comb begin
    s2_instr_s = 32'h0000_0000;
    if (!s1_valid_r) begin
      s2_instr_s = 32'h0000_0000;
    end else if (s1_err_r != ERR_NONE) begin
      s2_instr_s = NOP_INSTR;
    end else begin
      s2_instr_s = packed_s;
    end
  end

  // Stage 2: output register, frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_r <= 1'b0;
      s2_instr_r <= 32'h0000_0000;
      s2_err_r   <= ERR_NONE;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      s2_instr_r <= s2_instr_s;
      s2_err_r   <= s1_valid_r ? s1_err_r : ERR_NONE;
    end
  end

  // Saturating good/error word counters, bumped on each output handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_ok_r  <= 16'h0000;
      cnt_err_r <= 16'h0000;
    end else if (fire_s) begin
      if (s2_err_r == ERR_NONE) begin
        cnt_ok_r <= (cnt_ok_r == 16'hFFFF) ? cnt_ok_r : cnt_ok_r + 16'd1;
      end else begin
        cnt_err_r <= (cnt_err_r == 16'hFFFF) ? cnt_err_r : cnt_err_r + 16'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_r;
  assign bus.instr     = s2_instr_r;
  assign bus.err_code  = s2_err_r;
  assign bus.err       = |s2_err_r;
  assign bus.cnt_ok    = cnt_ok_r;
  assign bus.cnt_err   = cnt_err_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases, backpressure, reset
// mid-stream and a randomized round trip through a reference extender.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if bus ();
  instr_encoder dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [2:0]  src;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [1:0]  code;
  } out_t;

  req_t sent_q[$];
  out_t got_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_ok = 0;
  int   exp_err = 0;
  logic last_acc = 1'b0;

  function automatic req_t mk(input logic [2:0] src, input logic [31:0] imm, input logic [6:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3);
    req_t r;
    r.src = src; r.imm = imm; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3;
    return r;
  endfunction

  // Reference error model: immediates viewed as signed integers with per-format ranges.
  function automatic logic [1:0] model_err(input req_t r);
    longint s;
    s = longint'($signed(r.imm));
    if (r.src > 3'd5) return 2'd3;
    if ((r.src == 3'd2 || r.src == 3'd3) && r.imm[0]) return 2'd2;
    case (r.src)
      3'd0, 3'd1: return (s < -2048 || s > 2047) ? 2'd1 : 2'd0;
      3'd2:       return (s < -4096 || s > 4095) ? 2'd1 : 2'd0;
      3'd3:       return (s < -1048576 || s > 1048575) ? 2'd1 : 2'd0;
      default:    return (r.imm % 32'd4096 != 32'd0) ? 2'd1 : 2'd0;
    endcase
  endfunction

  // Reference immediate extender (RISC-V decode side).
  function automatic logic [31:0] extend(input logic [31:0] i, input logic [2:0] src);
    case (src)
      3'd0:       return {{20{i[31]}}, i[31:20]};
      3'd1:       return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:       return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:       return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4, 3'd5: return {i[31:12], 12'h000};
      default:    return 32'h0;
    endcase
  endfunction

  function automatic bit fields_ok(input logic [31:0] i, input req_t r);
    bit ok;
    ok = (i[6:0] == r.op);
    case (r.src)
      3'd0:       ok = ok && i[11:7] == r.rd && i[14:12] == r.f3 && i[19:15] == r.rs1;
      3'd1, 3'd2: ok = ok && i[14:12] == r.f3 && i[19:15] == r.rs1 && i[24:20] == r.rs2;
      default:    ok = ok && i[11:7] == r.rd;
    endcase
    return ok;
  endfunction

  task automatic drive(input req_t r);
    bus.in_valid = 1'b1;
    bus.imm_src = r.src; bus.imm = r.imm; bus.opcode = r.op;
    bus.rd = r.rd; bus.rs1 = r.rs1; bus.rs2 = r.rs2; bus.funct3 = r.f3;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // One clock: record accepted requests and emitted words, end at negedge.
  task automatic step();
    req_t r;
    out_t o;
    logic acc;
    logic emit;
    #1;
    acc  = bus.in_valid && bus.in_ready;
    emit = bus.out_valid && bus.out_ready;
    r = mk(bus.imm_src, bus.imm, bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.funct3);
    o.instr = bus.instr; o.err = bus.err; o.code = bus.err_code;
    @(posedge clk);
    if (rst && acc) sent_q.push_back(r);
    if (rst && emit) got_q.push_back(o);
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic send_get(input req_t r, output out_t o, output bit to);
    int n;
    to = 1'b0;
    o.instr = 32'h0; o.err = 1'b0; o.code = 2'd0;
    drive(r);
    n = 0;
    do begin step(); n++; end while (!last_acc && n < 50);
    idle();
    if (!last_acc) to = 1'b1;
    n = 0;
    while (got_q.size() == 0 && n < 50) begin step(); n++; end
    if (got_q.size() == 0) begin
      to = 1'b1;
    end else begin
      o = got_q.pop_front();
      if (sent_q.size() > 0) sent_q.delete(0);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.imm_src = 3'd0; bus.imm = 32'h5;
    bus.opcode = 7'h13; bus.rd = 5'd1; bus.rs1 = 5'd2; bus.rs2 = 5'd3; bus.funct3 = 3'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hs in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.instr !== 32'h0 || bus.err !== 1'b0 || bus.err_code !== 2'd0 ||
        bus.cnt_ok !== 16'd0 || bus.cnt_err !== 16'd0) begin
      errors++; $display("FAIL reset_out instr=%h err=%b code=%0d ok=%0d errc=%0d want all 0",
                         bus.instr, bus.err, bus.err_code, bus.cnt_ok, bus.cnt_err);
    end
    idle();
    rst = 1'b1;
    step();
  endtask

  task automatic test_directed();
    out_t o;
    bit   to;
    bus.out_ready = 1'b1;
    drive(mk(3'd0, 32'hFFFF_FFFF, 7'h13, 5'd5, 5'd1, 5'd0, 3'd0));
    step();
    idle();
    checks++;
    if (last_acc !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL i_lat1 acc=%b out_valid=%b want 1/0", last_acc, bus.out_valid);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.instr !== 32'hFFF0_8293 || bus.err_code !== 2'd0) begin
      errors++; $display("FAIL i_word valid=%b instr=%h code=%0d want 1/fff08293/0",
                         bus.out_valid, bus.instr, bus.err_code);
    end
    step();
    got_q.delete(); sent_q.delete(); exp_ok++;

    send_get(mk(3'd2, 32'h8, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0), o, to);
    checks++; exp_ok++;
    if (to || o.instr !== 32'h0020_8463 || o.code !== 2'd0 || o.err !== 1'b0) begin
      errors++; $display("FAIL b_word to=%b instr=%h code=%0d want 00208463/0", to, o.instr, o.code);
    end
    send_get(mk(3'd2, 32'h5, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0), o, to);
    checks++; exp_err++;
    if (to || o.instr !== 32'h0000_0013 || o.code !== 2'd2 || o.err !== 1'b1 || bus.cnt_err !== 16'd1) begin
      errors++; $display("FAIL b_align to=%b instr=%h code=%0d err=%b cnt_err=%0d want 13/2/1/1",
                         to, o.instr, o.code, o.err, bus.cnt_err);
    end
    send_get(mk(3'd4, 32'h1234_5000, 7'h37, 5'd10, 5'd0, 5'd0, 3'd0), o, to);
    checks++; exp_ok++;
    if (to || o.instr !== 32'h1234_5537 || o.code !== 2'd0) begin
      errors++; $display("FAIL u_word to=%b instr=%h code=%0d want 12345537/0", to, o.instr, o.code);
    end
    send_get(mk(3'd0, 32'h0000_0800, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0), o, to);
    checks++; exp_err++;
    if (to || o.code !== 2'd1 || o.instr !== 32'h0000_0013 || o.err !== 1'b1) begin
      errors++; $display("FAIL i_range to=%b instr=%h code=%0d want 13/1", to, o.instr, o.code);
    end
    send_get(mk(3'd7, 32'h0, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0), o, to);
    checks++; exp_err++;
    if (to || o.code !== 2'd3 || o.instr !== 32'h0000_0013 || o.err !== 1'b1) begin
      errors++; $display("FAIL illegal to=%b instr=%h code=%0d want 13/3", to, o.instr, o.code);
    end
    checks++;
    if (bus.cnt_ok !== 16'(exp_ok) || bus.cnt_err !== 16'(exp_err)) begin
      errors++; $display("FAIL dir_counts ok=%0d err=%0d want %0d/%0d", bus.cnt_ok, bus.cnt_err, exp_ok, exp_err);
    end
  endtask

  task automatic test_backpressure();
    req_t r[3];
    int   idx = 0;
    int   n;
    for (int k = 0; k < 3; k++) r[k] = mk(3'd0, 32'(k + 1), 7'h13, 5'd0, 5'd0, 5'd0, 3'd0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(r[idx]);
      step();
      if (last_acc) idx++;
      if (i >= 1) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.instr !== 32'h0010_0013) begin
          errors++; $display("FAIL bp_hold cyc=%0d valid=%b instr=%h want 1/00100013", i, bus.out_valid, bus.instr);
        end
      end
    end
    #1;
    checks++;
    if (idx != 2 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stall accepted=%0d in_ready=%b want 2/0", idx, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    n = 0;
    while (idx < 3 && n < 20) begin drive(r[idx]); step(); if (last_acc) idx++; n++; end
    idle();
    n = 0;
    while (got_q.size() < 3 && n < 20) begin step(); n++; end
    checks++;
    if (got_q.size() != 3) begin
      errors++; $display("FAIL bp_count got=%0d want 3", got_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_q[k].instr !== 32'h0000_0013 + (32'(k + 1) << 20)) begin
          errors++; $display("FAIL bp_order idx=%0d instr=%h want %h", k, got_q[k].instr,
                             32'h0000_0013 + (32'(k + 1) << 20));
        end
      end
    end
    exp_ok += 3;
    got_q.delete(); sent_q.delete();
    checks++;
    if (bus.cnt_ok !== 16'(exp_ok)) begin
      errors++; $display("FAIL bp_cnt ok=%0d want %0d", bus.cnt_ok, exp_ok);
    end
  endtask

  task automatic test_reset_midstream();
    int n;
    bus.out_ready = 1'b0;
    drive(mk(3'd0, 32'h10, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0)); step();
    drive(mk(3'd0, 32'h20, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0)); step();
    idle();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.cnt_ok !== 16'd0 || bus.cnt_err !== 16'd0) begin
      errors++; $display("FAIL rst_mid valid=%b in_ready=%b ok=%0d err=%0d want 0/1/0/0",
                         bus.out_valid, bus.in_ready, bus.cnt_ok, bus.cnt_err);
    end
    @(negedge clk);
    rst = 1'b1;
    sent_q.delete(); got_q.delete(); exp_ok = 0; exp_err = 0;
    bus.out_ready = 1'b1;
    drive(mk(3'd1, 32'hFFFF_FFF0, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2));
    step();
    idle();
    checks++;
    if (last_acc !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_lat1 acc=%b valid=%b want 1/0", last_acc, bus.out_valid);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || extend(bus.instr, 3'd1) !== 32'hFFFF_FFF0) begin
      errors++; $display("FAIL rst_lat2 valid=%b instr=%h want valid S word of fffffff0", bus.out_valid, bus.instr);
    end
    n = 0;
    while (n < 5) begin step(); n++; end
    checks++;
    if (got_q.size() != 1 || bus.cnt_ok !== 16'd1) begin
      errors++; $display("FAIL rst_discard words=%0d cnt_ok=%0d want 1/1", got_q.size(), bus.cnt_ok);
    end
    exp_ok = 1;
    got_q.delete(); sent_q.delete();
  endtask

  task automatic gen(output req_t r, output bit legal);
    int v;
    legal = ($urandom_range(0, 7) != 0);
    r = mk(3'(legal ? $urandom_range(0, 5) : $urandom_range(0, 7)), $urandom, 7'($urandom),
           5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom));
    if (legal) begin
      case (r.src)
        3'd0, 3'd1: begin v = int'($urandom_range(0, 4095)) - 2048; r.imm = 32'(v); end
        3'd2:       begin v = (int'($urandom_range(0, 4095)) - 2048) * 2; r.imm = 32'(v); end
        3'd3:       begin v = (int'($urandom_range(0, 1048575)) - 524288) * 2; r.imm = 32'(v); end
        default:    r.imm = $urandom & 32'hFFFF_F000;
      endcase
    end
  endtask

  task automatic test_random_roundtrip();
    req_t cur;
    req_t r;
    out_t o;
    bit   have = 1'b0;
    bit   legal;
    bit   ok;
    int   nlegal = 0;
    int   cyc = 0;
    int   n;
    logic [1:0] e;
    while ((nlegal < 10000 || have) && cyc < 80000) begin
      if (!have) begin gen(cur, legal); have = 1'b1; if (legal) nlegal++; end
      if ($urandom_range(0, 9) < 8) drive(cur); else idle();
      bus.out_ready = ($urandom_range(0, 9) < 7);
      step();
      cyc++;
      if (last_acc) have = 1'b0;
      if (cyc == 80000 || (nlegal >= 10000 && !have)) begin
        idle(); bus.out_ready = 1'b1;
        n = 0;
        while (got_q.size() + 0 < sent_q.size() && n < 20) begin step(); n++; end
      end
      while (got_q.size() > 0) begin
        o = got_q.pop_front();
        checks++;
        if (sent_q.size() == 0) begin
          errors++; $display("FAIL rand_extra instr=%h with no pending request", o.instr);
        end else begin
          r = sent_q.pop_front();
          e = model_err(r);
          if (e != 2'd0) begin
            ok = (o.instr === 32'h0000_0013 && o.err === 1'b1 && o.code === e);
            exp_err++;
          end else begin
            ok = (o.err === 1'b0 && o.code === 2'd0 && extend(o.instr, r.src) === r.imm && fields_ok(o.instr, r));
            exp_ok++;
          end
          if (!ok) begin
            errors++; $display("FAIL rand_word src=%0d imm=%h instr=%h err=%b code=%0d want code %0d",
                               r.src, r.imm, o.instr, o.err, o.code, e);
          end
        end
      end
    end
    checks++;
    if (cyc >= 80000 || sent_q.size() != 0) begin
      errors++; $display("FAIL rand_drain cycles=%0d pending=%0d want <80000/0", cyc, sent_q.size());
    end
    checks++;
    if (bus.cnt_ok !== 16'(exp_ok) || bus.cnt_err !== 16'(exp_err)) begin
      errors++; $display("FAIL rand_counts ok=%0d err=%0d want %0d/%0d", bus.cnt_ok, bus.cnt_err, exp_ok, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midstream();
    test_random_roundtrip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
